// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, the NOP encoding and the
// fetch-queue entry layout.
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_INST_W = 32;

  localparam logic [DEF_INST_W-1:0] INST_NOP = '0;

  typedef struct packed {
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_ADDR_W-1:0] pc4;
  } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO with push, pop, flush and occupancy count.
// Read data is forced to zero while the FIFO is empty.
module fq_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // A push into a full FIFO is legal only alongside a pop: it reuses the
  // slot the head is leaving, whose data has already been read this cycle.
  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: PC generator feeding a prefetch queue toward ID.
// Replaces the PC register and IF/ID latch; redirects flush the queue.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INST_W   = DEF_INST_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic                       imem_req_o,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic                       imem_ready_i,
  input  logic [INST_W-1:0]          imem_inst_i,
  output logic                       id_valid_o,
  output logic [INST_W-1:0]          id_inst_o,
  output logic [ADDR_W-1:0]          id_pc4_o,
  input  logic                       id_ready_i,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned ENT_W = INST_W + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc4;
  logic              pop, push;
  logic [ENT_W-1:0]  head;

  assign pc4        = pc_q + ADDR_W'(4);
  assign id_valid_o = (count_o != '0);
  assign pop        = id_valid_o & id_ready_i;

  // Allow a request into a full queue when the head drains the same cycle.
  assign imem_req_o = start_i & ~rst_i & ~redirect_i &
                      ((count_o < CNT_W'(DEPTH)) | pop);
  assign push       = imem_req_o & imem_ready_i;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i)  pc_d = redirect_pc_i;
    else if (push)   pc_d = pc4;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign imem_addr_o = pc_q;

  fq_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .wdata_i ({imem_inst_i, pc4}),
    .rdata_o (head),
    .count_o (count_o)
  );

  assign {id_inst_o, id_pc4_o} = head;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, stall/fill, redirect flush,
// memory back-pressure, PC wrap-around and reset-over-redirect.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_i, start_i, imem_ready_i, id_ready_i, redirect_i;
  logic [31:0] redirect_pc_i;

  logic        imem_req_o, id_valid_o;
  logic [31:0] imem_addr_o, imem_inst_i, id_inst_o, id_pc4_o;
  logic [2:0]  count_o;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_inst_in, w_inst, w_pc4;
  logic [2:0]  w_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  // Memory model: each instruction word equals its own address.
  assign imem_inst_i = imem_addr_o;
  assign w_inst_in   = w_addr;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_inst_i(imem_inst_i),
    .id_valid_o(id_valid_o), .id_inst_o(id_inst_o), .id_pc4_o(id_pc4_o),
    .id_ready_i(id_ready_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .count_o(count_o)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ready_i(imem_ready_i), .imem_inst_i(w_inst_in),
    .id_valid_o(w_valid), .id_inst_o(w_inst), .id_pc4_o(w_pc4),
    .id_ready_i(id_ready_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .count_o(w_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b1; imem_ready_i = 1'b1; id_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    tick(); tick();
    chk("rst_req", 64'(imem_req_o), 64'd0);
    chk("rst_addr", 64'(imem_addr_o), 64'h0);
    chk("rst_valid", 64'(id_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_inst", 64'(id_inst_o), 64'd0);
    chk("rst_pc4", 64'(id_pc4_o), 64'd0);
    chk("rst_waddr", 64'(w_addr), 64'hFFFF_FFFC);

    // Streaming at one instruction per cycle
    id_ready_i = 1'b1; rst_i = 1'b0; #1;
    chk("s_req1", 64'(imem_req_o), 64'd1);
    chk("s_addr1", 64'(imem_addr_o), 64'h0);
    tick();
    chk("s_valid", 64'(id_valid_o), 64'd1);
    chk("s_inst0", 64'(id_inst_o), 64'h0);
    chk("s_pc4_0", 64'(id_pc4_o), 64'h4);
    tick();
    chk("s_inst1", 64'(id_inst_o), 64'h4);
    chk("s_pc4_1", 64'(id_pc4_o), 64'h8);
    tick();
    chk("s_inst2", 64'(id_inst_o), 64'h8);
    chk("s_pc4_2", 64'(id_pc4_o), 64'hC);
    chk("s_count", 64'(count_o), 64'd1);

    // Decode stalled from reset: queue fills to DEPTH
    rst_i = 1'b1; id_ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("f_count", 64'(count_o), 64'd4);
    chk("f_req", 64'(imem_req_o), 64'd0);
    chk("f_addr", 64'(imem_addr_o), 64'h10);
    chk("f_head", 64'(id_inst_o), 64'h0);
    tick();
    chk("f_count_hold", 64'(count_o), 64'd4);
    chk("f_addr_hold", 64'(imem_addr_o), 64'h10);
    id_ready_i = 1'b1; #1;
    chk("f_req_pop", 64'(imem_req_o), 64'd1);
    tick();
    chk("f_count_pp", 64'(count_o), 64'd4);
    chk("f_head_pp", 64'(id_inst_o), 64'h4);
    chk("f_pc4_pp", 64'(id_pc4_o), 64'h8);
    chk("f_addr_pp", 64'(imem_addr_o), 64'h14);

    // Drain one entry with fetch disabled, then redirect at count 3
    start_i = 1'b0;
    tick();
    chk("r_count3", 64'(count_o), 64'd3);
    chk("r_addr_held", 64'(imem_addr_o), 64'h14);
    chk("r_head", 64'(id_inst_o), 64'h8);
    start_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h100; #1;
    chk("r_req", 64'(imem_req_o), 64'd0);
    tick();
    redirect_i = 1'b0;
    chk("r_count0", 64'(count_o), 64'd0);
    chk("r_valid0", 64'(id_valid_o), 64'd0);
    chk("r_addr", 64'(imem_addr_o), 64'h100);
    chk("r_inst0", 64'(id_inst_o), 64'd0);
    chk("r_pc4_0", 64'(id_pc4_o), 64'd0);
    tick();
    chk("r_tgt_inst", 64'(id_inst_o), 64'h100);
    chk("r_tgt_pc4", 64'(id_pc4_o), 64'h104);
    chk("r_tgt_count", 64'(count_o), 64'd1);
    tick();
    chk("r_next_inst", 64'(id_inst_o), 64'h104);

    // Memory back-pressure at PC 0x8, plus RESET_PC wrap on the second instance
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; id_ready_i = 1'b1; start_i = 1'b1; imem_ready_i = 1'b1;
    tick();
    chk("w_pc4_0", 64'(w_pc4), 64'h0);
    chk("w_inst_0", 64'(w_inst), 64'hFFFF_FFFC);
    chk("w_addr_1", 64'(w_addr), 64'h0);
    tick();
    chk("w_inst_1", 64'(w_inst), 64'h0);
    chk("w_pc4_1", 64'(w_pc4), 64'h4);
    chk("b_addr", 64'(imem_addr_o), 64'h8);
    chk("b_head", 64'(id_inst_o), 64'h4);
    imem_ready_i = 1'b0; id_ready_i = 1'b0; #1;
    chk("b_req", 64'(imem_req_o), 64'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("b_addr_stall", 64'(imem_addr_o), 64'h8);
      chk("b_count_stall", 64'(count_o), 64'd1);
      chk("b_req_stall", 64'(imem_req_o), 64'd1);
    end
    imem_ready_i = 1'b1;
    tick();
    chk("b_count_resume", 64'(count_o), 64'd2);
    chk("b_addr_resume", 64'(imem_addr_o), 64'hC);
    id_ready_i = 1'b1;
    tick();
    chk("b_head_resume", 64'(id_inst_o), 64'h8);
    chk("b_pc4_resume", 64'(id_pc4_o), 64'hC);

    // Reset wins over redirect with a full queue
    id_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("x_full", 64'(count_o), 64'd4);
    rst_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick();
    chk("x_count", 64'(count_o), 64'd0);
    chk("x_valid", 64'(id_valid_o), 64'd0);
    chk("x_addr", 64'(imem_addr_o), 64'h0);
    chk("x_waddr", 64'(w_addr), 64'hFFFF_FFFC);
    chk("x_req", 64'(imem_req_o), 64'd0);
    rst_i = 1'b0; redirect_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
